seq_writeback_regfile: RTL
==========================

Name: seq_writeback_regfile

Overview:
- Writeback stage and architectural register file for the Y86-64 SEQ processor.
- Derives dstE/dstM from the current instruction and commits valE/valM on the clock edge.
- Presents all 15 registers as parallel outputs, which feed decode's reg0..regE inputs.
- Tracks a sticky processor status: once halt or any error commits, further register writes are blocked.

Parameters:
- WIDTH, 64, register/data width in bits.
- RSP_INDEX, 4, register index used as the stack pointer for call/ret/pushq/popq.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  asynchronous active-high reset.
- icode  input  4  instruction code of the instruction being committed.
- rA  input  4  register A field; 0xF means none.
- rB  input  4  register B field; 0xF means none.
- cnd  input  1  condition result from execute; qualifies cmovXX.
- valE  input  WIDTH  execute result.
- valM  input  WIDTH  memory read result.
- hlt  input  1  fetch reports a halt instruction.
- invalid_instruction  input  1  fetch reports an illegal icode/ifun.
- invalid_instruction_address  input  1  fetch reports an instruction address out of range.
- dmem_error  input  1  memory stage reports a data address error.
- reg0..regE  output  WIDTH each (15 ports)  current register contents, index 0x0..0xE.
- stat  output  3  status: 1=AOK, 2=HLT, 3=ADR, 4=INS.
- halted  output  1  high whenever stat != AOK.
- dstE  output  4  combinational E destination for this cycle; 0xF if none.
- dstM  output  4  combinational M destination for this cycle; 0xF if none.

Behaviour:
- Reset (async, immediate):
  - all 15 registers = 0; stat = 1 (AOK); halted = 0.
  - Reset asserted mid-write wins; no write lands that edge.
- dstE is decided by icode:
  - 2 (rrmovq/cmovXX): rB if cnd=1, else 0xF.
  - 3 (irmovq), 6 (OPq): rB.
  - 8 (call), 9 (ret), A (pushq), B (popq): RSP_INDEX.
  - All other icodes: 0xF.
- dstM is decided by icode:
  - 5 (mrmovq), B (popq): rA.
  - All other icodes: 0xF.
- Write rule:
  - At posedge, if stat == AOK and no error/halt input is asserted: reg[dstE] <= valE when dstE != 0xF, and reg[dstM] <= valM when dstM != 0xF.
  - If dstE == dstM (popq %rsp), the dstM/valM write wins; only one write lands.
- Status state machine (states AOK, HLT, ADR, INS); priority of error inputs when several are asserted in the same cycle: ADR > INS > HLT.
  - AOK -> ADR: invalid_instruction_address or dmem_error.
  - AOK -> INS: invalid_instruction.
  - AOK -> HLT: hlt.
  - The causing instruction's register writes are suppressed in the transitioning cycle.
  - HLT/ADR/INS are terminal until rst; all writes blocked; stat holds.
- Read outputs reflect registered state only. A value written at edge N is visible after edge N; there is no same-cycle bypass.
- Index 0xF is never a storage location. Writes targeting 0xF are discarded.

Optional Feature:
- Macro WB_WRITE_COUNT_EN.
- When defined:
  - adds output write_count (32 bits), reset to 0.
  - increments by the number of register writes actually committed that edge: 0, 1, or 2.
  - popq %rsp counts 1.
  - saturates at 0xFFFFFFFF.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then irmovq (icode 3, rB=2, valE=0x1234) -> after edge, reg2=0x1234; all other registers 0; stat=1.
- cmovXX (icode 2, rB=3, valE=7) with cnd=0 -> dstE=0xF, reg3 unchanged. Repeat with cnd=1 -> reg3=7.
- popq (icode B, rA=4, valE=0x100, valM=0xABC) -> reg4=0xABC; write_count +1 when WB_WRITE_COUNT_EN is defined.
- popq (icode B, rA=1, valE=0x108, valM=0x55) -> reg4=0x108 and reg1=0x55; write_count +2.
- hlt=1 together with OPq (rB=5, valE=9) -> reg5 unchanged; stat=2; halted=1. A following irmovq is also blocked.
- dmem_error=1 and invalid_instruction=1 in the same cycle -> stat=3. Assert rst mid-cycle -> immediately stat=1 and all registers 0.

Source files
------------

// File: rtl/seq_writeback_regfile_if.sv
// Commit bus from the SEQ datapath into the writeback stage / register file.
interface seq_writeback_regfile_if #(
  parameter int unsigned WIDTH = 64
);
  logic [3:0]       icode;
  logic [3:0]       rA;
  logic [3:0]       rB;
  logic             cnd;
  logic [WIDTH-1:0] valE;
  logic [WIDTH-1:0] valM;
  logic             hlt;
  logic             invalid_instruction;
  logic             invalid_instruction_address;
  logic             dmem_error;

  modport master (
    output icode, rA, rB, cnd, valE, valM,
           hlt, invalid_instruction, invalid_instruction_address, dmem_error
  );

  modport slave (
    input  icode, rA, rB, cnd, valE, valM,
           hlt, invalid_instruction, invalid_instruction_address, dmem_error
  );
endinterface

// File: rtl/seq_writeback_regfile.sv
// Y86-64 SEQ writeback stage with 15-entry architectural register file and sticky status.
// Optional macro WB_WRITE_COUNT_EN adds a saturating committed-write counter.
module seq_writeback_regfile #(
  parameter int unsigned WIDTH     = 64,
  parameter int unsigned RSP_INDEX = 4
) (
  input  logic             clk,
  input  logic             rst,
  seq_writeback_regfile_if.slave bus,
  output logic [WIDTH-1:0] reg0,
  output logic [WIDTH-1:0] reg1,
  output logic [WIDTH-1:0] reg2,
  output logic [WIDTH-1:0] reg3,
  output logic [WIDTH-1:0] reg4,
  output logic [WIDTH-1:0] reg5,
  output logic [WIDTH-1:0] reg6,
  output logic [WIDTH-1:0] reg7,
  output logic [WIDTH-1:0] reg8,
  output logic [WIDTH-1:0] reg9,
  output logic [WIDTH-1:0] regA,
  output logic [WIDTH-1:0] regB,
  output logic [WIDTH-1:0] regC,
  output logic [WIDTH-1:0] regD,
  output logic [WIDTH-1:0] regE,
  output logic [2:0]       stat,
  output logic             halted,
  output logic [3:0]       dstE,
  output logic [3:0]       dstM
`ifdef WB_WRITE_COUNT_EN
  ,
  output logic [31:0]      write_count
`endif
);

  localparam int unsigned NREGS = 15;
  localparam logic [3:0]  RNONE = 4'hF;

  typedef enum logic [2:0] {
    S_AOK = 3'd1,
    S_HLT = 3'd2,
    S_ADR = 3'd3,
    S_INS = 3'd4
  } stat_t;

  stat_t            state;
  logic [WIDTH-1:0] regs [NREGS];
  logic             any_event;
  logic             commit_ok;
  logic             we_e;
  logic             we_m;

  // Destination decode from the committing instruction
  always_comb begin
    dstE = RNONE;
    dstM = RNONE;
    unique case (bus.icode)
      4'h2:                      dstE = bus.cnd ? bus.rB : RNONE;
      4'h3, 4'h6:                dstE = bus.rB;
      4'h8, 4'h9, 4'hA, 4'hB:    dstE = 4'(RSP_INDEX);
      default:                   dstE = RNONE;
    endcase
    unique case (bus.icode)
      4'h5, 4'hB:                dstM = bus.rA;
      default:                   dstM = RNONE;
    endcase
  end

  // Writes only while AOK and no halt/error is being raised this cycle;
  // a dstE colliding with dstM is dropped so the M write lands alone.
  assign any_event = bus.hlt | bus.invalid_instruction |
                     bus.invalid_instruction_address | bus.dmem_error;
  assign commit_ok = (state == S_AOK) & ~any_event;
  assign we_m      = commit_ok & (dstM != RNONE);
  assign we_e      = commit_ok & (dstE != RNONE) & ~(we_m & (dstE == dstM));

  // Register file storage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NREGS); i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < int'(NREGS); i++) begin
        if (we_e && dstE == 4'(i)) regs[i] <= bus.valE;
        if (we_m && dstM == 4'(i)) regs[i] <= bus.valM;
      end
    end
  end

  // Sticky status machine; ADR outranks INS outranks HLT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_AOK;
      halted <= 1'b0;
    end else begin
      unique case (state)
        S_AOK: begin
          if (bus.invalid_instruction_address || bus.dmem_error) begin
            state  <= S_ADR;
            halted <= 1'b1;
          end else if (bus.invalid_instruction) begin
            state  <= S_INS;
            halted <= 1'b1;
          end else if (bus.hlt) begin
            state  <= S_HLT;
            halted <= 1'b1;
          end
        end
        S_HLT, S_ADR, S_INS: begin
          state  <= state;
          halted <= 1'b1;
        end
        default: begin
          state  <= S_AOK;
          halted <= 1'b0;
        end
      endcase
    end
  end

  assign stat = state;

  assign reg0 = regs[0];
  assign reg1 = regs[1];
  assign reg2 = regs[2];
  assign reg3 = regs[3];
  assign reg4 = regs[4];
  assign reg5 = regs[5];
  assign reg6 = regs[6];
  assign reg7 = regs[7];
  assign reg8 = regs[8];
  assign reg9 = regs[9];
  assign regA = regs[10];
  assign regB = regs[11];
  assign regC = regs[12];
  assign regD = regs[13];
  assign regE = regs[14];

`ifdef WB_WRITE_COUNT_EN
  logic [32:0] count_sum;

  assign count_sum = 33'(write_count) + 33'(we_e) + 33'(we_m);

  // Saturating count of register writes that actually land
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write_count <= '0;
    end else begin
      write_count <= count_sum[32] ? 32'hFFFF_FFFF : count_sum[31:0];
    end
  end
`endif

endmodule
